multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum number of cycles a state waits for mem_ready before abandoning the access.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  7  instruction bits [6:0] from the instruction register; sampled only in DECODE and MEM_ADDR.
REQ-005 mem_ready  input  1  memory handshake; the access completes in any cycle where it is high while mem_read or mem_write is high.
REQ-006 alu_op  output  3  ALU class passed to the ALU control stage:
- 000 = add
- 001 = branch compare
- 010 = R-type
- 011 = I-type
- 100 = LUI
- 101 = AUIPC
REQ-007 alu_src_a  output  2  ALU A operand select: 00 PC, 01 old PC, 10 rs1.
REQ-008 alu_src_b  output  2  ALU B operand select: 00 rs2, 01 constant 4, 10 immediate.
REQ-009 result_src  output  2  result select: 00 ALU result, 01 memory data, 10 alu_out register.
REQ-010 Single-bit outputs, each with meaning as named:
- pc_write
- ir_write
- iord (1 = data address, 0 = PC)
- mem_read
- mem_write
- reg_write
- branch
- illegal_inst
- bus_error
REQ-011 state  output  4  current state code, for debug.

Function
REQ-012 State codes:
- FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ALU_WB 4
- MEM_ADDR 5, MEM_READ 6, MEM_WB 7, MEM_WRITE 8
- BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13, ILLEGAL 14
- Code 15 is unused; from 15 the next state is FETCH and all outputs are 0.
REQ-013 Outputs are Moore, decoded from state only (except ir_write and pc_write in FETCH); any output not listed for a state is 0.
REQ-014 FETCH:
- outputs: mem_read=1, iord=0, a=00, b=01, alu_op=000, result_src=00, ir_write=pc_write=mem_ready
- next: DECODE when mem_ready, else stay.
REQ-015 DECODE:
- outputs: a=01, b=10, alu_op=000 (precomputes branch/JAL target into alu_out)
- next: 0110011 EXEC_R; 0010011 EXEC_I; 0000011/0100011 MEM_ADDR; 1100011 BRANCH; 1101111 JAL; 1100111 JALR; 0110111 LUI; 0010111 AUIPC; any other opcode ILLEGAL.
REQ-016 EXEC_R: a=10, b=00, alu_op=010; next ALU_WB.
REQ-017 EXEC_I: a=10, b=10, alu_op=011; next ALU_WB.
REQ-018 ALU_WB: reg_write=1, result_src=10; next FETCH.
REQ-019 MEM_ADDR: a=10, b=10, alu_op=000; next MEM_READ if opcode=0000011, else MEM_WRITE.
REQ-020 MEM_READ: mem_read=1, iord=1; next MEM_WB on mem_ready, else stay.
REQ-021 MEM_WB: reg_write=1, result_src=01; next FETCH.
REQ-022 MEM_WRITE: mem_write=1, iord=1; next FETCH on mem_ready, else stay.
REQ-023 BRANCH: a=10, b=00, alu_op=001, branch=1, result_src=10; next FETCH.
REQ-024 JAL: pc_write=1, result_src=10, a=01, b=01, alu_op=000; next ALU_WB (writes old PC+4 as the link).
REQ-025 JALR: a=10, b=10, alu_op=000; next JAL.
REQ-026 LUI and AUIPC:
- LUI: b=10, alu_op=100
- AUIPC: a=01, b=10, alu_op=101
- both: next ALU_WB.
REQ-027 ILLEGAL: illegal_inst=1 for exactly one cycle; next FETCH.
REQ-028 Wait counter: 4 bits minimum, sized to hold WAIT_MAX.
- Cleared on every state change.
- Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready low.
REQ-029 If the wait counter equals WAIT_MAX with mem_ready still low:
- bus_error=1 for that cycle
- next state is FETCH, with no register or PC write.
- mem_ready high in that same cycle takes priority: the access completes normally.
REQ-030 Cycle counts: R/I/LUI/AUIPC take 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 5, each assuming zero-wait memory.

Reset
REQ-031 While reset is high:
- state=FETCH and the wait counter is 0, immediately and independent of clk
- all outputs are forced to 0.
REQ-032 Reset asserted mid-instruction aborts it with no further write strobes; after release the first edge evaluates FETCH.

Verification
REQ-033 Zero-wait ADD (opcode 0110011), mem_ready=1: states 0,1,2,4,0; alu_op=010 in EXEC_R; reg_write=1 only in ALU_WB.
REQ-034 Load (0000011), mem_ready low 3 cycles in MEM_READ: MEM_READ holds 4 cycles, then MEM_WB with result_src=01, reg_write=1.
REQ-035 JALR (1100111): states 0,1,11,10,4,0; pc_write=1 in JAL; alu_op=000 throughout.
REQ-036 Opcode 1111111: states 0,1,14,0; illegal_inst high exactly one cycle; no reg_write, pc_write or mem_write.
REQ-037 Store (0100011) with mem_ready held low, WAIT_MAX=15: bus_error high one cycle after 16 cycles in MEM_WRITE, then FETCH; mem_write never completes.
REQ-038 Reset pulsed asynchronously during MEM_WRITE: state=0 and all outputs 0 before the next clk edge; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory side (slave).
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       pc_write;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       branch;
  logic       illegal_inst;
  logic       bus_error;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src, pc_write, ir_write, iord,
           mem_read, mem_write, reg_write, branch, illegal_inst, bus_error, state
  );

  modport slave (
    output opcode, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src, pc_write, ir_write, iord,
           mem_read, mem_write, reg_write, branch, illegal_inst, bus_error, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32 main controller: Moore outputs decoded from the state register, one state per cycle.
// Memory states wait on mem_ready and abandon the access to FETCH after WAIT_MAX idle cycles.
module multicycle_control #(
  parameter int WAIT_MAX = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);
  localparam int CW = ($clog2(WAIT_MAX + 1) < 4) ? 4 : $clog2(WAIT_MAX + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,  DECODE   = 4'd1,  EXEC_R    = 4'd2,  EXEC_I = 4'd3,
    ALU_WB    = 4'd4,  MEM_ADDR = 4'd5,  MEM_READ  = 4'd6,  MEM_WB = 4'd7,
    MEM_WRITE = 4'd8,  BRANCH   = 4'd9,  JAL       = 4'd10, JALR   = 4'd11,
    LUI       = 4'd12, AUIPC    = 4'd13, ILLEGAL   = 4'd14, UNUSED = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic          waiting, timeout;

  always_comb begin
    waiting = (state_q == FETCH || state_q == MEM_READ || state_q == MEM_WRITE) && !bus.mem_ready;
    timeout = waiting && (wait_q == CW'(WAIT_MAX));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default:           state_d = ILLEGAL;
        endcase
      end
      EXEC_R, EXEC_I, LUI, AUIPC, JAL: state_d = ALU_WB;
      ALU_WB, MEM_WB, BRANCH, ILLEGAL: state_d = FETCH;
      MEM_ADDR:  state_d = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (bus.mem_ready) state_d = MEM_WB;
      MEM_WRITE: if (bus.mem_ready) state_d = FETCH;
      JALR:      state_d = JAL;
      default:   state_d = FETCH;
    endcase
    // An abandoned access returns to FETCH; mem_ready in the same cycle wins since timeout needs it low.
    if (timeout) state_d = FETCH;
  end

  // A FETCH timeout keeps the state code, so the counter is also cleared on timeout to restart the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || timeout)
        wait_q <= '0;
      else if (waiting)
        wait_q <= wait_q + 1'b1;
    end
  end

  always_comb begin
    bus.alu_op       = 3'b000;
    bus.alu_src_a    = 2'b00;
    bus.alu_src_b    = 2'b00;
    bus.result_src   = 2'b00;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.iord         = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.branch       = 1'b0;
    bus.illegal_inst = 1'b0;
    bus.bus_error    = 1'b0;
    bus.state        = 4'd0;
    if (!reset) begin
      bus.state     = state_q;
      bus.bus_error = timeout;
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        DECODE:    begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; end
        EXEC_R:    begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b00; bus.alu_op = 3'b010; end
        EXEC_I:    begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b10; bus.alu_op = 3'b011; end
        ALU_WB:    begin bus.reg_write = 1'b1; bus.result_src = 2'b10; end
        MEM_ADDR:  begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b10; end
        MEM_READ:  begin bus.mem_read = 1'b1; bus.iord = 1'b1; end
        MEM_WB:    begin bus.reg_write = 1'b1; bus.result_src = 2'b01; end
        MEM_WRITE: begin bus.mem_write = 1'b1; bus.iord = 1'b1; end
        BRANCH: begin
          bus.alu_src_a  = 2'b10;
          bus.alu_op     = 3'b001;
          bus.branch     = 1'b1;
          bus.result_src = 2'b10;
        end
        // Link write of old PC+4 happens in the following ALU_WB.
        JAL: begin
          bus.pc_write   = 1'b1;
          bus.result_src = 2'b10;
          bus.alu_src_a  = 2'b01;
          bus.alu_src_b  = 2'b01;
        end
        JALR:      begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b10; end
        LUI:       begin bus.alu_src_b = 2'b10; bus.alu_op = 3'b100; end
        AUIPC:     begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; bus.alu_op = 3'b101; end
        ILLEGAL:   bus.illegal_inst = 1'b1;
        default:   bus.state = state_q;
      endcase
    end
  end
endmodule
